vector_issue_control: RTL

//  Parametrised decode-and-issue stage for the vector CPU. Accepts an opcode from

---
 rtl/vector_issue_control.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vector_issue_control.sv
`default_nettype none
// ============================================================================
// Module   : vector_issue_control
// Purpose  : Decode-and-issue stage; registers the decoded control bundle into
//            Execute and sequences vector ops over BEATS element groups.
// Revision : 1.0  initial release
// ============================================================================
module vector_issue_control #(
    parameter int OPCODE_WIDTH = 5,
    parameter int VLEN         = 8,
    parameter int LANES        = 4,
    localparam int BEATS       = VLEN / LANES,
    localparam int BW          = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    validD,
    input  logic [OPCODE_WIDTH-1:0] opcodeD,
    output logic                    readyD,
    input  logic                    stallE,
    input  logic                    flushE,
    output logic                    validE,
    output logic [13:0]             ctrlE,
    output logic [BW-1:0]           beatE,
    output logic                    lastBeatE,
    output logic                    illegalE
);

    localparam logic [BW-1:0] c_LAST_BEAT = BW'(BEATS - 1);

    localparam logic [OPCODE_WIDTH-1:0] c_OP_MOV   = OPCODE_WIDTH'(5'b00010);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_ADD   = OPCODE_WIDTH'(5'b00100);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_SUB   = OPCODE_WIDTH'(5'b00101);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_DIV   = OPCODE_WIDTH'(5'b00110);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_MUL   = OPCODE_WIDTH'(5'b00111);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_CMP   = OPCODE_WIDTH'(5'b01010);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_BE    = OPCODE_WIDTH'(5'b01011);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_JMP   = OPCODE_WIDTH'(5'b01110);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_VLDR  = OPCODE_WIDTH'(5'b10000);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_VSTR  = OPCODE_WIDTH'(5'b10001);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_VSADD = OPCODE_WIDTH'(5'b10100);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_VADD  = OPCODE_WIDTH'(5'b11100);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_VSSUB = OPCODE_WIDTH'(5'b11101);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_VSMUL = OPCODE_WIDTH'(5'b11110);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t          r_state,    w_stateNext;
    logic [13:0]     r_ctrl,     w_ctrlNext;
    logic [BW-1:0]   r_beat,     w_beatNext;
    logic            r_illegal,  w_illegalNext;
    logic            r_isVector, w_isVectorNext;

    logic [13:0]     w_decCtrl;
    logic            w_decIllegal;
    logic            w_decVector;
    logic            w_transfer;

    // Flags {useScalarAlu..outFlag} followed by the 4-bit ALU control
    always_comb begin
        w_decCtrl    = 14'd0;
        w_decIllegal = 1'b0;
        w_decVector  = 1'b0;
        case (opcodeD)
            c_OP_MOV:   w_decCtrl = {10'b1100101000, 4'h2};
            c_OP_ADD:   w_decCtrl = {10'b1111001000, 4'h4};
            c_OP_SUB:   w_decCtrl = {10'b1111001000, 4'h5};
            c_OP_DIV:   w_decCtrl = {10'b1110101000, 4'h6};
            c_OP_MUL:   w_decCtrl = {10'b1110001000, 4'h7};
            c_OP_CMP:   w_decCtrl = {10'b1110100000, 4'h5};
            c_OP_BE:    w_decCtrl = {10'b1000100000, 4'h2};
            c_OP_JMP:   w_decCtrl = {10'b1000100000, 4'h2};
            c_OP_VLDR:  begin w_decCtrl = {10'b1010010100, 4'hF}; w_decVector = 1'b1; end
            c_OP_VSTR:  begin w_decCtrl = {10'b1010000011, 4'hF}; w_decVector = 1'b1; end
            c_OP_VSADD: begin w_decCtrl = {10'b0001000100, 4'h4}; w_decVector = 1'b1; end
            c_OP_VADD:  begin w_decCtrl = {10'b0000000100, 4'h4}; w_decVector = 1'b1; end
            c_OP_VSSUB: begin w_decCtrl = {10'b0001000100, 4'hD}; w_decVector = 1'b1; end
            c_OP_VSMUL: begin w_decCtrl = {10'b0001000100, 4'h2}; w_decVector = 1'b1; end
            default:    w_decIllegal = 1'b1;
        endcase
    end

    assign validE     = (r_state == S_ISSUE);
    assign lastBeatE  = validE & (~r_isVector | (r_beat == c_LAST_BEAT));
    assign readyD     = ~flushE & ~stallE & (~validE | lastBeatE);
    assign w_transfer = validD & readyD;
    assign ctrlE      = r_ctrl;
    assign beatE      = r_beat;
    assign illegalE   = r_illegal;

    always_comb begin
        w_stateNext    = r_state;
        w_ctrlNext     = r_ctrl;
        w_beatNext     = r_beat;
        w_illegalNext  = r_illegal;
        w_isVectorNext = r_isVector;
        if (flushE) begin
            w_stateNext    = S_IDLE;
            w_ctrlNext     = 14'd0;
            w_beatNext     = '0;
            w_illegalNext  = 1'b0;
            w_isVectorNext = 1'b0;
        end else if (!stallE) begin
            if (validE && !lastBeatE) begin
                w_beatNext = r_beat + BW'(1);
            end else if (w_transfer) begin
                // A new op loads on the same edge that retires the previous last beat
                w_stateNext    = S_ISSUE;
                w_ctrlNext     = w_decCtrl;
                w_beatNext     = '0;
                w_illegalNext  = w_decIllegal;
                w_isVectorNext = w_decVector;
            end else begin
                w_stateNext    = S_IDLE;
                w_ctrlNext     = 14'd0;
                w_beatNext     = '0;
                w_illegalNext  = 1'b0;
                w_isVectorNext = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 14'd0;
            r_beat     <= '0;
            r_illegal  <= 1'b0;
            r_isVector <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_ctrl     <= w_ctrlNext;
            r_beat     <= w_beatNext;
            r_illegal  <= w_illegalNext;
            r_isVector <= w_isVectorNext;
        end
    end

endmodule
`default_nettype wire
